// File: rtl/systolic3x3_drain_if.sv
// Result stream from the 3x3 systolic drain: one word per valid/ready handshake.
// master = drain (producer), slave = downstream consumer.
interface systolic3x3_drain_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/systolic3x3_drain.sv
// Result-side unloader for the 3x3 systolic array. Counts enabled clocks from
// START, snapshots C0..C8 after LAT edges, then streams the words row-major
// over a valid/ready interface.
// Optional: define SYSTOLIC_DRAIN_CHECKSUM_EN to append a 10th word (index 9)
// holding the mod-2^DATA_W sum of the nine snapshot words.
module systolic3x3_drain #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LAT    = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                start,
    input  logic [DATA_W-1:0]   c0,
    input  logic [DATA_W-1:0]   c1,
    input  logic [DATA_W-1:0]   c2,
    input  logic [DATA_W-1:0]   c3,
    input  logic [DATA_W-1:0]   c4,
    input  logic [DATA_W-1:0]   c5,
    input  logic [DATA_W-1:0]   c6,
    input  logic [DATA_W-1:0]   c7,
    input  logic [DATA_W-1:0]   c8,
    systolic3x3_drain_if.master drain_bus,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
    localparam int unsigned NWORDS = 10;
`else
    localparam int unsigned NWORDS = 9;
`endif
    localparam logic [3:0]  LAST_IDX = 4'(NWORDS - 1);
    localparam int unsigned CNT_W    = $clog2(LAT + 1);

    typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   snap_q [NWORDS];
    logic [DATA_W-1:0]   c_vec  [9];
    logic                snap_load;
    logic                done_d;
    logic                hs;

    assign c_vec[0] = c0;
    assign c_vec[1] = c1;
    assign c_vec[2] = c2;
    assign c_vec[3] = c3;
    assign c_vec[4] = c4;
    assign c_vec[5] = c5;
    assign c_vec[6] = c6;
    assign c_vec[7] = c7;
    assign c_vec[8] = c8;

    assign hs = drain_bus.out_valid && drain_bus.out_ready;

    // Next-state logic: count to LAT while enabled, then step through the snapshot.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        snap_load = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWait;
                    cnt_d   = CNT_W'(1);
                end
            end
            StWait: begin
                if (en) begin
                    if (cnt_q == CNT_W'(LAT)) begin
                        snap_load = 1'b1;
                        idx_d     = 4'd0;
                        cnt_d     = '0;
                        state_d   = StDrain;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers; overrun is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done    <= done_d;
            // START is only accepted from IDLE, including on the final drain edge.
            if (start && (state_q != StIdle)) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    // Checksum of the live array outputs, captured together with the words.
    always_comb begin
        csum = '0;
        for (int i = 0; i < 9; i++) begin
            csum = csum + c_vec[i];
        end
    end
`endif

    // Snapshot register decouples the drain from further array activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                snap_q[i] <= '0;
            end
        end else if (snap_load) begin
            for (int i = 0; i < 9; i++) begin
                snap_q[i] <= c_vec[i];
            end
`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
            snap_q[9] <= csum;
`endif
        end
    end

    // Outputs are forced to zero outside DRAIN so stale snapshot data never shows.
    always_comb begin
        drain_bus.out_valid = (state_q == StDrain);
        drain_bus.out_idx   = idx_q;
        drain_bus.out_data  = drain_bus.out_valid ? snap_q[idx_q] : '0;
        drain_bus.out_last  = drain_bus.out_valid && (idx_q == LAST_IDX);
        busy                = (state_q != StIdle);
    end

endmodule

// File: tb/tb_systolic3x3_drain.sv
// Directed bench for systolic3x3_drain: 3x3 product of A=[1..9], B=[10..18].
module tb_systolic3x3_drain;

    localparam int unsigned LAT = 7;
`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
    localparam int NW = 10;
`else
    localparam int NW = 9;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cin [9];
    logic        busy, done, overrun;
    logic [31:0] exp_w [10];
    int          tests = 0;
    int          fails = 0;

    systolic3x3_drain_if #(.DATA_W(32)) bus ();

    systolic3x3_drain #(.DATA_W(32), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .c0        (cin[0]),
        .c1        (cin[1]),
        .c2        (cin[2]),
        .c3        (cin[3]),
        .c4        (cin[4]),
        .c5        (cin[5]),
        .c6        (cin[6]),
        .c7        (cin[7]),
        .c8        (cin[8]),
        .drain_bus (bus),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Correct product only when good=1, otherwise distinct garbage.
    task automatic set_c(input bit good);
        for (int i = 0; i < 9; i++) begin
            cin[i] = good ? exp_w[i] : (32'hA5A5_0000 + 32'(i) * 32'd17);
        end
    endtask

    task automatic start_and_wait(input int gap, input int restart_at);
        int snap_edge;
        snap_edge = LAT + gap;
        en = 1'b1;
        start = 1'b1;
        set_c(1'b0);
        step();
        start = 1'b0;
        check("busy_wait", {31'd0, busy}, 32'd1);
        for (int e = 1; e <= snap_edge; e++) begin
            en = !(gap > 0 && e >= 2 && e < 2 + gap);
            start = (e == restart_at);
            set_c(e == snap_edge);
            step();
            start = 1'b0;
            if (e < snap_edge) check("valid_pre_snap", {31'd0, bus.out_valid}, 32'd0);
        end
        en = 1'b1;
        set_c(1'b0);
        check("valid_at_snap", {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic run_drain(input bit stall, input bit start_on_last, input int nwords);
        int  wi;
        int  p;
        bit  rdy;
        wi = 0;
        p = 0;
        while (wi < nwords && p < 80) begin
            check("valid", {31'd0, bus.out_valid}, 32'd1);
            check("idx", {28'd0, bus.out_idx}, 32'(wi));
            check("data", bus.out_data, exp_w[wi]);
            check("last", {31'd0, bus.out_last}, {31'd0, wi == NW - 1});
            rdy = !stall || (p % 3 == 0);
            bus.out_ready = rdy;
            start = start_on_last && rdy && (wi == NW - 1);
            step();
            start = 1'b0;
            if (rdy) wi++;
            p++;
        end
        bus.out_ready = 1'b1;
        check("drain_words", 32'(wi), 32'(nwords));
    endtask

    task automatic finish_drain();
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("valid_after", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("done_clear", {31'd0, done}, 32'd0);
    endtask

    initial begin
        exp_w[0] = 32'd84;  exp_w[1] = 32'd90;  exp_w[2] = 32'd96;
        exp_w[3] = 32'd201; exp_w[4] = 32'd216; exp_w[5] = 32'd231;
        exp_w[6] = 32'd318; exp_w[7] = 32'd342; exp_w[8] = 32'd366;
        exp_w[9] = 32'd1944;
        bus.out_ready = 1'b1;
        set_c(1'b0);

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_idx", {28'd0, bus.out_idx}, 32'd0);
        check("rst_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Basic drain, ready held high
        start_and_wait(0, 0);
        run_drain(1'b0, 1'b0, NW);
        finish_drain();

        // Ready pattern 1,0,0,1,...
        start_and_wait(0, 0);
        run_drain(1'b1, 1'b0, NW);
        finish_drain();

        // EN low for 3 cycles in WAIT delays the snapshot by 3 edges
        start_and_wait(3, 0);
        run_drain(1'b0, 1'b0, NW);
        finish_drain();
        check("no_overrun_yet", {31'd0, overrun}, 32'd0);

        // Second START at k+4 is ignored and sets OVERRUN
        start_and_wait(0, 4);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        run_drain(1'b0, 1'b0, NW);
        finish_drain();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-drain once idx 4 has been handed over
        start_and_wait(0, 0);
        run_drain(1'b0, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_data", bus.out_data, 32'd0);
        check("mid_rst_idx", {28'd0, bus.out_idx}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

        // Full drain after reset; START on the final handshake edge is ignored
        start_and_wait(0, 0);
        run_drain(1'b0, 1'b1, NW);
        finish_drain();
        check("start_on_last_overrun", {31'd0, overrun}, 32'd1);
        check("start_on_last_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/systolic3x3_drain.md
# systolic3x3_drain

Result-side unloader for the 3x3 systolic array. It counts array clocks from the first skewed operand beat. At a fixed latency it snapshots the nine accumulator outputs C0..C8, then streams them out one word per handshake in row-major order over a valid/ready interface. It sits between the array outputs and any downstream consumer (writeback buffer, host FIFO), freeing the array for the next operand stream.

## Interface
Parameters:
- DATA_W, 32, width of each accumulator word
- LAT, 7, rising edges (with EN high) from the START-sampling edge to the snapshot edge; 7 matches a 3x3 array fed with 5 skewed beats

Ports:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- EN  in  1  shared array enable; counter advances only when high
- START  in  1  one-cycle pulse, high on the same edge the array captures operand beat 0
- C0..C8  in  DATA_W each  array accumulator outputs, row-major (C0 = row0/col0, C8 = row2/col2)
- OUT_DATA  out  DATA_W  current result word
- OUT_IDX  out  4  index 0..8 of OUT_DATA (9 = checksum, see Configuration)
- OUT_VALID  out  1  OUT_DATA/OUT_IDX valid
- OUT_READY  in  1  consumer accepts the word when high together with OUT_VALID
- OUT_LAST  out  1  high with the final word of a drain
- BUSY  out  1  high in WAIT or DRAIN
- DONE  out  1  one-cycle pulse after the last handshake
- OVERRUN  out  1  sticky; START seen while BUSY

## Operation
- FSM states: IDLE, WAIT, DRAIN.
- IDLE: START=1 -> WAIT, cnt <= 1.
- WAIT: on each edge with EN=1, cnt increments. On the edge where cnt==LAT and EN=1:
  - C0..C8 latch into a 9-word snapshot register.
  - idx <= 0.
  - FSM -> DRAIN.
- EN=0 in WAIT freezes cnt. The array is frozen by the same EN, so the snapshot stays aligned.
- DRAIN:
  - OUT_VALID=1, OUT_DATA=snap[idx], OUT_IDX=idx.
  - On OUT_VALID&OUT_READY: idx increments. The last word's handshake -> IDLE with DONE=1 for one cycle.
- OUT_DATA and OUT_IDX hold stable while OUT_VALID=1 and OUT_READY=0. OUT_VALID never drops before the handshake.
- Draining is independent of EN. The snapshot decouples drain from further array activity, and C0..C8 changes during DRAIN are ignored.
- START while BUSY: ignored; OVERRUN <= 1. OVERRUN clears only on reset.
- START on the same edge as the final DRAIN handshake: treated as busy (ignored, OVERRUN set). A new drain starts only from IDLE.
- No arithmetic on data. Words pass through unmodified at DATA_W.

## Timing
- Reset values (asynchronous, immediate on RST_N low):
  - FSM=IDLE, cnt=0, idx=0.
  - OUT_DATA=0, OUT_IDX=0, OUT_VALID=0, OUT_LAST=0, BUSY=0, DONE=0, OVERRUN=0.
  - Snapshot=0.
- Reset mid-WAIT or mid-DRAIN aborts. No partial words are emitted after release.
- START sampled at edge k, EN continuously high:
  - Snapshot at edge k+LAT.
  - OUT_VALID high from edge k+LAT until the final handshake.
- With OUT_READY held high, words 0..8 leave on edges k+LAT+1 .. k+LAT+9.
- DONE is high for the cycle after the last handshake edge. BUSY falls on that same edge.
- Minimum START-to-START spacing without overrun: LAT+9+1 cycles.
- OUT_LAST = OUT_VALID && idx==last.

## Configuration
- SYSTOLIC_DRAIN_CHECKSUM_EN defined:
  - A 10th word follows idx 8: OUT_IDX=9, OUT_DATA = sum of the nine snapshot words mod 2^DATA_W.
  - The checksum is computed at snapshot time.
  - OUT_LAST moves to idx 9. Minimum spacing grows by 1.
- Undefined: 9 words only, OUT_LAST on idx 8, no adder logic.

## Test plan
- Array fed with A=[1..9] and B=[10..18] skewed, START with beat 0, OUT_READY=1 -> words 84,90,96,201,216,231,318,342,366 at idx 0..8. OUT_VALID first goes high at edge k+7. OUT_LAST on 366. DONE one cycle after.
- Same stimulus with OUT_READY toggling 1,0,0,1,... -> identical word sequence. Each word is held stable through the stall cycles, with no duplicates or drops.
- EN low for 3 cycles during WAIT -> snapshot delayed 3 edges, values unchanged (84..366).
- START pulsed again at edge k+4 -> ignored, OVERRUN=1 and stays 1. The first drain completes normally.
- RST_N low mid-DRAIN after idx 4 -> all outputs 0 immediately. A new START after release gives a full 9-word drain from idx 0.
- With SYSTOLIC_DRAIN_CHECKSUM_EN -> a 10th word of 1944 at OUT_IDX=9 with OUT_LAST. idx 8 no longer asserts OUT_LAST.
